axi_isolate_ctrl_mc: RTL and testbench

Multi-channel AXI isolation controller, the generalised successor of the single-port isolate path in the peripheral wrappers.
- Tracks outstanding write and read transactions for NumChannels manager ports using AW/AR/B/R-last handshake strobes.
- On request, blocks new AW/AR issue and drains each channel independently, then reports it isolated.
- A per-channel drain timeout forces isolation and raises a sticky error, so a hung peripheral cannot stall power-down.

---
 rtl/axi_isolate_ctrl_pkg.sv | 18 +
 rtl/axi_isolate_ctrl_ch.sv | 124 ++++++++++++
 rtl/axi_isolate_ctrl_mc.sv | 53 +++++
 tb/tb_axi_isolate_ctrl_mc.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_isolate_ctrl_pkg.sv
// Shared types and helpers for the multi-channel AXI isolation controller.
package axi_isolate_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2,
        FORCED   = 2'd3
    } iso_state_e;

    // Width needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/axi_isolate_ctrl_ch.sv
// One isolation channel: pending counters, drain FSM, drain timeout and sticky error.
module axi_isolate_ctrl_ch
    import axi_isolate_ctrl_pkg::*;
#(
    parameter int unsigned MaxPending    = 8,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntWidth      = cnt_width(MaxPending),
    parameter int unsigned ToWidth       = cnt_width(TimeoutCycles)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                isolate_req_i,
    input  logic                aw_hs_i,
    input  logic                ar_hs_i,
    input  logic                b_hs_i,
    input  logic                r_last_hs_i,
    input  logic                err_clr_i,
    output logic                block_aw_o,
    output logic                block_ar_o,
    output logic                isolated_o,
    output logic                timeout_o,
    output logic                err_o,
    output logic [CntWidth-1:0] wr_pending_o,
    output logic [CntWidth-1:0] rd_pending_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxPending);
    localparam logic [ToWidth-1:0]  ToMax  = ToWidth'(TimeoutCycles);

    iso_state_e          state_q, state_d;
    logic [CntWidth-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [ToWidth-1:0]  to_q, to_d;
    logic                wr_err, rd_err, timeout_d, err_d;
    logic                block_aw_d, block_ar_d, isolated_d;

    // Returns {error, next count}; simultaneous up/down cancel out.
    function automatic logic [CntWidth:0] cnt_next(input logic [CntWidth-1:0] cnt,
                                                   input logic up, input logic dn);
        logic [CntWidth:0] res;
        res = {1'b0, cnt};
        if (up && !dn) begin
            if (cnt == MaxCnt) res[CntWidth] = 1'b1;
            else               res[CntWidth-1:0] = cnt + 1'b1;
        end else if (dn && !up) begin
            if (cnt == '0) res[CntWidth] = 1'b1;
            else           res[CntWidth-1:0] = cnt - 1'b1;
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        to_d      = to_q;
        timeout_d = 1'b0;
        {wr_err, wr_d} = cnt_next(wr_q, aw_hs_i && (state_q != FORCED), b_hs_i);
        {rd_err, rd_d} = cnt_next(rd_q, ar_hs_i && (state_q != FORCED), r_last_hs_i);
        unique case (state_q)
            RUN: begin
                if (isolate_req_i) begin
                    state_d = DRAIN;
                    to_d    = '0;
                end
            end
            DRAIN: begin
                if (wr_d == '0 && rd_d == '0) begin
                    state_d = isolate_req_i ? ISOLATED : RUN;
                end else if (!isolate_req_i) begin
                    state_d = RUN;
                    to_d    = '0;
                end else if (TimeoutCycles != 0 && to_q == ToMax) begin
                    state_d   = FORCED;
                    timeout_d = 1'b1;
                end else if (to_q != '1) begin
                    to_d = to_q + 1'b1;
                end
            end
            ISOLATED: begin
                if (!isolate_req_i) state_d = RUN;
            end
            FORCED: begin
                if (!isolate_req_i) begin
                    state_d = RUN;
                    wr_d    = '0;
                    rd_d    = '0;
                end
            end
            default: state_d = ISOLATED;
        endcase
        if (wr_err || rd_err || timeout_d) err_d = 1'b1;
        else if (err_clr_i)                err_d = 1'b0;
        else                               err_d = err_o;
        block_aw_d = (state_d != RUN) || (wr_d == MaxCnt);
        block_ar_d = (state_d != RUN) || (rd_d == MaxCnt);
        isolated_d = (state_q == ISOLATED) || (state_q == FORCED);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ISOLATED;
            wr_q         <= '0;
            rd_q         <= '0;
            to_q         <= '0;
            block_aw_o   <= 1'b1;
            block_ar_o   <= 1'b1;
            isolated_o   <= 1'b1;
            timeout_o    <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            to_q         <= to_d;
            block_aw_o   <= block_aw_d;
            block_ar_o   <= block_ar_d;
            isolated_o   <= isolated_d;
            timeout_o    <= timeout_d;
            err_o        <= err_d;
        end
    end

    assign wr_pending_o = wr_q;
    assign rd_pending_o = rd_q;

endmodule

// File: rtl/axi_isolate_ctrl_mc.sv
// Multi-channel AXI isolation controller: NumChannels independent drain/isolate channels.
module axi_isolate_ctrl_mc
    import axi_isolate_ctrl_pkg::*;
#(
    parameter int unsigned NumChannels   = 4,
    parameter int unsigned MaxPending    = 8,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntWidth      = cnt_width(MaxPending),
    parameter int unsigned ToWidth       = cnt_width(TimeoutCycles)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumChannels-1:0]          isolate_req_i,
    input  logic [NumChannels-1:0]          aw_hs_i,
    input  logic [NumChannels-1:0]          ar_hs_i,
    input  logic [NumChannels-1:0]          b_hs_i,
    input  logic [NumChannels-1:0]          r_last_hs_i,
    output logic [NumChannels-1:0]          block_aw_o,
    output logic [NumChannels-1:0]          block_ar_o,
    output logic [NumChannels-1:0]          isolated_o,
    output logic [NumChannels-1:0]          timeout_o,
    output logic [NumChannels-1:0]          err_o,
    input  logic [NumChannels-1:0]          err_clr_i,
    output logic [NumChannels*CntWidth-1:0] wr_pending_o,
    output logic [NumChannels*CntWidth-1:0] rd_pending_o
);

    for (genvar i = 0; i < NumChannels; i++) begin : g_ch
        axi_isolate_ctrl_ch #(
            .MaxPending   (MaxPending),
            .TimeoutCycles(TimeoutCycles),
            .CntWidth     (CntWidth),
            .ToWidth      (ToWidth)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .isolate_req_i(isolate_req_i[i]),
            .aw_hs_i      (aw_hs_i[i]),
            .ar_hs_i      (ar_hs_i[i]),
            .b_hs_i       (b_hs_i[i]),
            .r_last_hs_i  (r_last_hs_i[i]),
            .err_clr_i    (err_clr_i[i]),
            .block_aw_o   (block_aw_o[i]),
            .block_ar_o   (block_ar_o[i]),
            .isolated_o   (isolated_o[i]),
            .timeout_o    (timeout_o[i]),
            .err_o        (err_o[i]),
            .wr_pending_o (wr_pending_o[i*CntWidth +: CntWidth]),
            .rd_pending_o (rd_pending_o[i*CntWidth +: CntWidth])
        );
    end

endmodule

// File: tb/tb_axi_isolate_ctrl_mc.sv
// Self-checking bench: directed sequences, a vector table and a randomized run against a reference model.
module tb_axi_isolate_ctrl_mc;

    localparam int NCH  = 4;
    localparam int MAXP = 8;
    localparam int TO   = 16;
    localparam int CW   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req, aw, ar, b, r, clr;
    logic [NCH-1:0]    block_aw, block_ar, isolated, timeout, err;
    logic [NCH*CW-1:0] wr_pend, rd_pend;

    int checks = 0;
    int errors = 0;

    axi_isolate_ctrl_mc #(
        .NumChannels  (NCH),
        .MaxPending   (MAXP),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .isolate_req_i(req),
        .aw_hs_i      (aw),
        .ar_hs_i      (ar),
        .b_hs_i       (b),
        .r_last_hs_i  (r),
        .block_aw_o   (block_aw),
        .block_ar_o   (block_ar),
        .isolated_o   (isolated),
        .timeout_o    (timeout),
        .err_o        (err),
        .err_clr_i    (clr),
        .wr_pending_o (wr_pend),
        .rd_pending_o (rd_pend)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] wr_of(input int ch);
        return wr_pend[ch*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] rd_of(input int ch);
        return rd_pend[ch*CW +: CW];
    endfunction

    // ---------------- reference model (integer counts, per-channel mode) ----------------
    typedef enum int {M_RUN, M_DRAIN, M_HELD, M_FORCED} mmode_e;
    mmode_e m_mode[NCH];
    int     m_wr[NCH], m_rd[NCH], m_age[NCH];
    bit     m_iso[NCH], m_to[NCH], m_err[NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = M_HELD;
            m_wr[c] = 0; m_rd[c] = 0; m_age[c] = 0;
            m_iso[c] = 1; m_to[c] = 0; m_err[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            bit set, up_w, up_r;
            int nw, nr;
            set  = 0;
            up_w = aw[c] && m_mode[c] != M_FORCED;
            up_r = ar[c] && m_mode[c] != M_FORCED;
            nw = m_wr[c];
            nr = m_rd[c];
            if (up_w && !b[c]) begin
                if (nw == MAXP) set = 1; else nw++;
            end else if (b[c] && !up_w) begin
                if (nw == 0) set = 1; else nw--;
            end
            if (up_r && !r[c]) begin
                if (nr == MAXP) set = 1; else nr++;
            end else if (r[c] && !up_r) begin
                if (nr == 0) set = 1; else nr--;
            end
            m_iso[c] = (m_mode[c] == M_HELD || m_mode[c] == M_FORCED);
            m_to[c]  = 0;
            case (m_mode[c])
                M_RUN: if (req[c]) begin m_mode[c] = M_DRAIN; m_age[c] = 0; end
                M_DRAIN: begin
                    if (nw == 0 && nr == 0) m_mode[c] = req[c] ? M_HELD : M_RUN;
                    else if (!req[c]) m_mode[c] = M_RUN;
                    else if (m_age[c] == TO) begin
                        m_mode[c] = M_FORCED; m_to[c] = 1; set = 1;
                    end else m_age[c]++;
                end
                M_HELD: if (!req[c]) m_mode[c] = M_RUN;
                M_FORCED: if (!req[c]) begin m_mode[c] = M_RUN; nw = 0; nr = 0; end
                default: ;
            endcase
            m_wr[c] = nw;
            m_rd[c] = nr;
            if (set) m_err[c] = 1;
            else if (clr[c]) m_err[c] = 0;
        end
    endtask

    task automatic model_compare(input int cyc);
        logic [NCH-1:0]    e_baw, e_bar, e_iso, e_to, e_err;
        logic [NCH*CW-1:0] e_wr, e_rd;
        for (int c = 0; c < NCH; c++) begin
            e_baw[c] = (m_mode[c] != M_RUN) || (m_wr[c] == MAXP);
            e_bar[c] = (m_mode[c] != M_RUN) || (m_rd[c] == MAXP);
            e_iso[c] = m_iso[c];
            e_to[c]  = m_to[c];
            e_err[c] = m_err[c];
            e_wr[c*CW +: CW] = CW'(m_wr[c]);
            e_rd[c*CW +: CW] = CW'(m_rd[c]);
        end
        check($sformatf("rnd%0d block_aw", cyc), 32'(block_aw), 32'(e_baw));
        check($sformatf("rnd%0d block_ar", cyc), 32'(block_ar), 32'(e_bar));
        check($sformatf("rnd%0d isolated", cyc), 32'(isolated), 32'(e_iso));
        check($sformatf("rnd%0d timeout", cyc),  32'(timeout),  32'(e_to));
        check($sformatf("rnd%0d err", cyc),      32'(err),      32'(e_err));
        check($sformatf("rnd%0d wr_pend", cyc),  32'(wr_pend),  32'(e_wr));
        check($sformatf("rnd%0d rd_pend", cyc),  32'(rd_pend),  32'(e_rd));
    endtask

    // ---------------- vector table for channel 3 counter rules ----------------
    typedef struct {
        logic        aw;
        logic        b;
        logic        clr;
        logic [CW-1:0] exp_wr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic seen_early;

        vecs[0] = '{aw: 1, b: 0, clr: 0, exp_wr: 1, exp_err: 0};
        vecs[1] = '{aw: 1, b: 0, clr: 0, exp_wr: 2, exp_err: 0};
        vecs[2] = '{aw: 1, b: 1, clr: 0, exp_wr: 2, exp_err: 0};
        vecs[3] = '{aw: 0, b: 1, clr: 0, exp_wr: 1, exp_err: 0};
        vecs[4] = '{aw: 0, b: 1, clr: 0, exp_wr: 0, exp_err: 0};
        vecs[5] = '{aw: 0, b: 1, clr: 0, exp_wr: 0, exp_err: 1};
        vecs[6] = '{aw: 0, b: 0, clr: 1, exp_wr: 0, exp_err: 0};
        vecs[7] = '{aw: 1, b: 1, clr: 0, exp_wr: 0, exp_err: 0};

        rst = 1'b1;
        req = '0; aw = '0; ar = '0; b = '0; r = '0; clr = '0;
        tick(); tick();
        check("rst isolated", 32'(isolated), 32'hF);
        check("rst block_aw", 32'(block_aw), 32'hF);
        check("rst block_ar", 32'(block_ar), 32'hF);
        check("rst err",      32'(err),      32'h0);
        check("rst timeout",  32'(timeout),  32'h0);
        check("rst wr_pend",  32'(wr_pend),  32'h0);
        rst = 1'b0;
        tick(); tick();
        check("run isolated", 32'(isolated), 32'h0);
        check("run block_aw", 32'(block_aw), 32'h0);

        // Ch0: 3 writes, isolate, drain with spaced responses
        aw[0] = 1; tick(); tick(); tick(); aw[0] = 0;
        check("ch0 wr3", 32'(wr_of(0)), 32'd3);
        req[0] = 1; tick();
        check("ch0 block_aw", 32'(block_aw[0]), 32'd1);
        check("ch0 block_ar", 32'(block_ar[0]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            repeat (4) tick();
            check($sformatf("ch0 iso before b%0d", k), 32'(isolated[0]), 32'd0);
            b[0] = 1; tick(); b[0] = 0;
        end
        check("ch0 wr0", 32'(wr_of(0)), 32'd0);
        tick();
        check("ch0 isolated", 32'(isolated[0]), 32'd1);
        check("ch0 no timeout", 32'(err[0]), 32'd0);
        req[0] = 0; tick(); tick();
        check("ch0 released", 32'(isolated[0]), 32'd0);

        // Ch1: stuck read forces isolation after TO+1 drain cycles
        ar[1] = 1; tick(); ar[1] = 0;
        check("ch1 rd1", 32'(rd_of(1)), 32'd1);
        req[1] = 1; tick();
        seen_early = 1'b0;
        for (int k = 0; k < TO; k++) begin
            tick();
            if (timeout[1]) seen_early = 1'b1;
        end
        check("ch1 early timeout", 32'(seen_early), 32'd0);
        tick();
        check("ch1 timeout pulse", 32'(timeout), 32'h2);
        check("ch1 err", 32'(err), 32'h2);
        check("ch1 iso lag", 32'(isolated[1]), 32'd0);
        tick();
        check("ch1 timeout end", 32'(timeout[1]), 32'd0);
        check("ch1 forced iso", 32'(isolated[1]), 32'd1);
        ar[1] = 1; tick(); ar[1] = 0;
        check("ch1 forced ignores ar", 32'(rd_of(1)), 32'd1);
        check("ch1 others running", 32'(isolated), 32'h2);
        req[1] = 0; tick();
        check("ch1 counts cleared", 32'(rd_of(1)), 32'd0);
        check("ch1 err sticky", 32'(err[1]), 32'd1);
        clr[1] = 1; tick(); clr[1] = 0;
        check("ch1 err clr", 32'(err[1]), 32'd0);

        // Ch2: saturation at MaxPending
        aw[2] = 1;
        repeat (MAXP - 1) tick();
        check("ch2 block below max", 32'(block_aw[2]), 32'd0);
        tick();
        check("ch2 block at max", 32'(block_aw[2]), 32'd1);
        check("ch2 wr max", 32'(wr_of(2)), 32'(MAXP));
        tick(); aw[2] = 0;
        check("ch2 wr held", 32'(wr_of(2)), 32'(MAXP));
        check("ch2 ovf err", 32'(err[2]), 32'd1);
        clr[2] = 1; tick(); clr[2] = 0;
        check("ch2 err clr", 32'(err[2]), 32'd0);
        aw[2] = 1; clr[2] = 1; tick(); aw[2] = 0; clr[2] = 0;
        check("ch2 set beats clr", 32'(err[2]), 32'd1);
        clr[2] = 1; tick(); clr[2] = 0;
        b[2] = 1; repeat (MAXP) tick(); b[2] = 0;
        check("ch2 drained", 32'(wr_of(2)), 32'd0);
        check("ch2 err clean", 32'(err[2]), 32'd0);

        // Ch3: table-driven counter rules
        foreach (vecs[i]) begin
            aw[3] = vecs[i].aw; b[3] = vecs[i].b; clr[3] = vecs[i].clr;
            tick();
            check($sformatf("vec%0d wr3", i),  32'(wr_of(3)), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d err3", i), 32'(err[3]),   32'(vecs[i].exp_err));
        end
        aw[3] = 0; b[3] = 0; clr[3] = 0;

        // Asynchronous reset in the middle of a drain
        aw[0] = 1; repeat (5) tick(); aw[0] = 0;
        req[0] = 1; tick();
        check("rstmid wr5", 32'(wr_of(0)), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("rstmid wr", 32'(wr_pend), 32'h0);
        check("rstmid rd", 32'(rd_pend), 32'h0);
        check("rstmid iso", 32'(isolated), 32'hF);
        check("rstmid baw", 32'(block_aw), 32'hF);
        check("rstmid bar", 32'(block_ar), 32'hF);
        req = '0;
        tick();

        // Randomized run against the reference model
        model_reset();
        rst = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(19) == 0) req[c] = ~req[c];
                aw[c]  = ($urandom_range(3) == 0);
                ar[c]  = ($urandom_range(3) == 0);
                b[c]   = (c == 3) ? ($urandom_range(15) == 0) : ($urandom_range(3) == 0);
                r[c]   = (c == 3) ? ($urandom_range(15) == 0) : ($urandom_range(3) == 0);
                clr[c] = ($urandom_range(31) == 0);
            end
            tick();
            model_step();
            model_compare(cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
